// File: rtl/flex_counter_pkg.sv
// Shared types and default widths for the flex counter.
//   mode_t  : counting behaviour at the ends of the range (3 = reserved, behaves as WRAP)
//   state_t : one-shot control state
package flex_counter_pkg;

    localparam int CNT_BITS_DEF      = 4;
    localparam int PRESCALE_BITS_DEF = 4;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_t;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage

// File: rtl/flex_counter_pro_if.sv
// Control/status bundle of the flex counter.
//   master : drives the controls, observes the status (bench / parent block)
//   slave  : the counter itself
// Controls: clear, count_enable, load, load_val, dir, mode, rollover_val, prescale_val
// Status  : count_out, rollover_flag, tc_pulse, done, busy
interface flex_counter_pro_if
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS  = CNT_BITS_DEF,
    parameter int PRESCALE_BITS = PRESCALE_BITS_DEF
);
    logic                     clear;
    logic                     count_enable;
    logic                     load;
    logic [NUM_CNT_BITS-1:0]  load_val;
    logic                     dir;
    logic [1:0]               mode;
    logic [NUM_CNT_BITS-1:0]  rollover_val;
    logic [PRESCALE_BITS-1:0] prescale_val;
    logic [NUM_CNT_BITS-1:0]  count_out;
    logic                     rollover_flag;
    logic                     tc_pulse;
    logic                     done;
    logic                     busy;

    modport master (
        output clear, count_enable, load, load_val, dir, mode, rollover_val, prescale_val,
        input  count_out, rollover_flag, tc_pulse, done, busy
    );

    modport slave (
        input  clear, count_enable, load, load_val, dir, mode, rollover_val, prescale_val,
        output count_out, rollover_flag, tc_pulse, done, busy
    );
endinterface

// File: rtl/flex_prescaler.sv
// Programmable prescaler: emits tick on every (prescale_val+1)-th enabled cycle.
//   CLK, nRST    : clock, async active-low reset
//   clear_i      : synchronous restart of the prescale count
//   en           : advance the prescale count
//   prescale_val : terminal prescale count
//   tick         : combinational, high on the enabled cycle that completes a period
module flex_prescaler
    import flex_counter_pkg::*;
#(
    parameter int PRESCALE_BITS = PRESCALE_BITS_DEF
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     clear_i,
    input  logic                     en,
    input  logic [PRESCALE_BITS-1:0] prescale_val,
    output logic                     tick
);
    logic [PRESCALE_BITS-1:0] pre_q;
    logic [PRESCALE_BITS-1:0] pre_d;

    assign tick = en && (pre_q == prescale_val);

    always_comb begin
        pre_d = pre_q;
        if (clear_i || tick) begin
            pre_d = '0;
        end else if (en) begin
            // Lowering prescale_val below pre_q lets this run around the full range once.
            pre_d = pre_q + PRESCALE_BITS'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
endmodule

// File: rtl/flex_counter_pro.sv
// Flex counter: up/down over 1..rollover_val with wrap / saturate / one-shot ends,
// parallel load, prescaled ticks, registered rollover flag, terminal-entry pulse
// and one-shot done/busy status.
//   CLK, nRST : clock, async active-low reset
//   ctrl_if   : slave side of flex_counter_pro_if (controls in, status out)
//
// state | meaning
// RUN   | ticks advance the count
// DONE  | one-shot reached terminal; ticks ignored until clear or load
module flex_counter_pro
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS  = CNT_BITS_DEF,
    parameter int PRESCALE_BITS = PRESCALE_BITS_DEF
) (
    input  logic                CLK,
    input  logic                nRST,
    flex_counter_pro_if.slave   ctrl_if
);
    logic [NUM_CNT_BITS-1:0] rv;
    logic [NUM_CNT_BITS-1:0] term;
    logic [NUM_CNT_BITS-1:0] cnt_q;
    logic [NUM_CNT_BITS-1:0] cnt_d;
    logic                    flag_q;
    logic                    tc_q;
    logic                    done_q;
    logic                    busy_q;
    state_t                  state_q;
    logic                    tick;
    logic                    hold_mode;
    logic                    oneshot;
    logic                    next_hit;
    logic                    load_hit;

    flex_prescaler #(.PRESCALE_BITS(PRESCALE_BITS)) u_prescaler (
        .CLK          (CLK),
        .nRST         (nRST),
        .clear_i      (ctrl_if.clear | ctrl_if.load),
        .en           (ctrl_if.count_enable),
        .prescale_val (ctrl_if.prescale_val),
        .tick         (tick)
    );

    assign rv        = ctrl_if.rollover_val;
    assign term      = ctrl_if.dir ? rv : NUM_CNT_BITS'(1);
    assign oneshot   = (ctrl_if.mode == MODE_ONESHOT);
    assign hold_mode = (ctrl_if.mode == MODE_SAT) || oneshot;

    always_comb begin
        cnt_d = cnt_q;
        if (rv == '0) begin
            cnt_d = '0;
        end else if (ctrl_if.dir) begin
            if (cnt_q < rv) begin
                cnt_d = cnt_q + NUM_CNT_BITS'(1);
            end else if (!hold_mode) begin
                cnt_d = NUM_CNT_BITS'(1);
            end
        end else begin
            // Out-of-range values (0 or above the top) re-enter at the top of the range.
            if ((cnt_q == '0) || (cnt_q > rv)) begin
                cnt_d = rv;
            end else if (cnt_q == NUM_CNT_BITS'(1)) begin
                if (!hold_mode) begin
                    cnt_d = rv;
                end
            end else begin
                cnt_d = cnt_q - NUM_CNT_BITS'(1);
            end
        end
    end

    // A zero range has no valid terminal value.
    assign next_hit = (cnt_d == term) && (rv != '0);
    assign load_hit = (ctrl_if.load_val == term) && (rv != '0);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            tc_q <= 1'b0;
            if (ctrl_if.clear) begin
                state_q <= RUN;
                cnt_q   <= '0;
                flag_q  <= 1'b0;
                done_q  <= 1'b0;
                busy_q  <= 1'b1;
            end else if (ctrl_if.load) begin
                state_q <= RUN;
                cnt_q   <= ctrl_if.load_val;
                flag_q  <= load_hit;
                done_q  <= 1'b0;
                busy_q  <= 1'b1;
            end else if (tick && (state_q == RUN)) begin
                cnt_q  <= cnt_d;
                flag_q <= next_hit;
                tc_q   <= next_hit && (cnt_q != term);
                if (oneshot && next_hit) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    assign ctrl_if.count_out     = cnt_q;
    assign ctrl_if.rollover_flag = flag_q;
    assign ctrl_if.tc_pulse      = tc_q;
    assign ctrl_if.done          = done_q;
    assign ctrl_if.busy          = busy_q;
endmodule

// File: tb/tb_flex_counter_pro.sv
module tb_flex_counter_pro;
    import flex_counter_pkg::*;

    localparam int NB   = 4;
    localparam int PB   = 4;
    localparam int PMOD = 1 << PB;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    flex_counter_pro_if #(.NUM_CNT_BITS(NB), .PRESCALE_BITS(PB)) bus ();

    flex_counter_pro #(.NUM_CNT_BITS(NB), .PRESCALE_BITS(PB)) dut (
        .CLK     (clk),
        .nRST    (nrst),
        .ctrl_if (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: count, prescale position, flag, pulse, one-shot finished
    int m_cnt, m_pre, m_flag, m_tc, m_done;
    bit cmp_en = 1'b0;

    int exp_up_c[7]   = '{1, 2, 3, 4, 5, 1, 2};
    int exp_up_f[7]   = '{0, 0, 0, 0, 1, 0, 0};
    int exp_dn_c[8]   = '{6, 5, 4, 3, 2, 1, 1, 1};
    int exp_dn_f[8]   = '{0, 0, 0, 0, 0, 1, 1, 1};
    int exp_dn_t[8]   = '{0, 0, 0, 0, 0, 1, 0, 0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt = 0; m_pre = 0; m_flag = 0; m_tc = 0; m_done = 0;
    endfunction

    // Where a tick takes the count, from the range rules alone.
    function automatic int ref_next(input int c, input int rv, input int up, input int hold);
        if (rv == 0)              return 0;
        if (up != 0) begin
            if (c < rv)           return c + 1;
            return (hold != 0) ? c : 1;
        end
        if (c == 0 || c > rv)     return rv;
        if (c == 1)               return (hold != 0) ? 1 : rv;
        return c - 1;
    endfunction

    function automatic void model_step();
        int rv, termv, nxt, md, hold;
        bit tk;
        if (!nrst) begin
            model_reset();
            return;
        end
        rv    = int'(bus.rollover_val);
        termv = bus.dir ? rv : 1;
        md    = int'(bus.mode);
        hold  = (md == 1 || md == 2) ? 1 : 0;
        tk    = bus.count_enable && (m_pre == int'(bus.prescale_val));
        m_tc  = 0;
        if (bus.clear) begin
            model_reset();
        end else if (bus.load) begin
            m_cnt  = int'(bus.load_val);
            m_pre  = 0;
            m_done = 0;
            m_flag = (m_cnt == termv && rv != 0) ? 1 : 0;
        end else begin
            if (tk)                    m_pre = 0;
            else if (bus.count_enable) m_pre = (m_pre + 1) % PMOD;
            if (tk && m_done == 0) begin
                nxt    = ref_next(m_cnt, rv, bus.dir ? 1 : 0, hold);
                m_flag = (nxt == termv && rv != 0) ? 1 : 0;
                m_tc   = (m_flag == 1 && m_cnt != termv) ? 1 : 0;
                m_cnt  = nxt;
                if (md == 2 && m_flag == 1) m_done = 1;
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_count", int'(bus.count_out), m_cnt);
            chk("cmp_flag",  int'(bus.rollover_flag), m_flag);
            chk("cmp_tc",    int'(bus.tc_pulse), m_tc);
            chk("cmp_done",  int'(bus.done), m_done);
            chk("cmp_busy",  int'(bus.busy), 1 - m_done);
        end
    end

    task automatic do_clear();
        bus.clear = 1'b1;
        bus.count_enable = 1'b0;
        cyc();
        bus.clear = 1'b0;
    endtask

    initial begin
        int tc_sum;
        bus.clear = 1'b0; bus.count_enable = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        bus.dir = 1'b1; bus.mode = 2'd0; bus.rollover_val = 4'd5; bus.prescale_val = '0;
        model_reset();
        #12;
        chk("rst_count", int'(bus.count_out), 0);
        chk("rst_flag",  int'(bus.rollover_flag), 0);
        chk("rst_tc",    int'(bus.tc_pulse), 0);
        chk("rst_done",  int'(bus.done), 0);
        chk("rst_busy",  int'(bus.busy), 1);
        cmp_en = 1'b1;
        @(posedge clk); #1;
        nrst = 1'b1;

        // Up WRAP over 1..5, tick every cycle
        do_clear();
        bus.count_enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("upwrap_count", int'(bus.count_out), exp_up_c[i]);
            chk("upwrap_flag",  int'(bus.rollover_flag), exp_up_f[i]);
            chk("upwrap_tc",    int'(bus.tc_pulse), exp_up_f[i]);
        end

        // Prescale by 3, with an enable gap that freezes everything
        bus.rollover_val = 4'd3; bus.prescale_val = 4'd2;
        do_clear();
        bus.count_enable = 1'b1;
        cyc(); chk("pre_c1", int'(bus.count_out), 0);
        cyc(); chk("pre_c2", int'(bus.count_out), 0);
        cyc(); chk("pre_c3", int'(bus.count_out), 1);
        bus.count_enable = 1'b0;
        repeat (4) cyc();
        chk("pre_frozen", int'(bus.count_out), 1);
        bus.count_enable = 1'b1;
        cyc(); cyc(); chk("pre_resume2", int'(bus.count_out), 1);
        cyc();        chk("pre_resume3", int'(bus.count_out), 2);

        // ONESHOT up to 4, reload and finish again
        bus.rollover_val = 4'd4; bus.prescale_val = '0; bus.mode = 2'd2;
        do_clear();
        bus.count_enable = 1'b1;
        repeat (4) cyc();
        chk("os_count", int'(bus.count_out), 4);
        chk("os_done",  int'(bus.done), 1);
        chk("os_busy",  int'(bus.busy), 0);
        repeat (10) cyc();
        chk("os_hold", int'(bus.count_out), 4);
        bus.load = 1'b1; bus.load_val = 4'd2;
        cyc();
        bus.load = 1'b0;
        chk("os_load_count", int'(bus.count_out), 2);
        chk("os_load_done",  int'(bus.done), 0);
        cyc(); chk("os_r3", int'(bus.count_out), 3);
        cyc(); chk("os_r4", int'(bus.count_out), 4);
        chk("os_done2", int'(bus.done), 1);
        cyc(); chk("os_r4hold", int'(bus.count_out), 4);

        // Down SATURATE over 1..6
        bus.rollover_val = 4'd6; bus.mode = 2'd1; bus.dir = 1'b0;
        do_clear();
        bus.count_enable = 1'b1;
        tc_sum = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            tc_sum += int'(bus.tc_pulse);
            chk("dnsat_count", int'(bus.count_out), exp_dn_c[i]);
            chk("dnsat_flag",  int'(bus.rollover_flag), exp_dn_f[i]);
            chk("dnsat_tc",    int'(bus.tc_pulse), exp_dn_t[i]);
        end
        chk("dnsat_tc_once", tc_sum, 1);

        // clear beats load; out-of-range load wraps on the next up tick
        bus.clear = 1'b1; bus.load = 1'b1; bus.load_val = 4'd7; bus.count_enable = 1'b0;
        cyc();
        chk("clrld_count", int'(bus.count_out), 0);
        chk("clrld_flag",  int'(bus.rollover_flag), 0);
        bus.clear = 1'b0; bus.dir = 1'b1; bus.mode = 2'd0; bus.rollover_val = 4'd5;
        bus.prescale_val = '0; bus.load_val = 4'd9;
        cyc();
        bus.load = 1'b0;
        chk("ld9_count", int'(bus.count_out), 9);
        bus.count_enable = 1'b1;
        cyc();
        chk("ld9_wrap", int'(bus.count_out), 1);

        // Asynchronous reset mid-count, then a full prescale period before the first step
        bus.rollover_val = 4'd8; bus.prescale_val = 4'd1;
        do_clear();
        bus.count_enable = 1'b1;
        repeat (6) cyc();
        chk("ar_before", int'(bus.count_out), 3);
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        chk("ar_count", int'(bus.count_out), 0);
        chk("ar_flag",  int'(bus.rollover_flag), 0);
        chk("ar_done",  int'(bus.done), 0);
        chk("ar_busy",  int'(bus.busy), 1);
        cyc(); cyc();
        nrst = 1'b1;
        cyc(); chk("ar_first1", int'(bus.count_out), 0);
        cyc(); chk("ar_first2", int'(bus.count_out), 1);

        // Randomized run against the reference
        for (int i = 0; i < 3000; i++) begin
            bus.clear        = ($urandom_range(0, 31) == 0);
            bus.load         = ($urandom_range(0, 15) == 0);
            bus.load_val     = NB'($urandom_range(0, 15));
            bus.count_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 40) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 50) == 0) bus.rollover_val = NB'($urandom_range(0, 15));
            if ($urandom_range(0, 60) == 0) bus.prescale_val = PB'($urandom_range(0, 3));
            cyc();
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flex_counter_pro.md
Name: flex_counter_pro

Overview:
Parametrised next-generation flex counter: up/down counting, selectable wrap / saturate / one-shot modes, parallel load and a programmable prescaler. It keeps the 1..rollover_val counting range and the registered rollover flag of the existing counter. It adds an entry-edge terminal pulse and a done/busy status for one-shot use. It sits in timer/baud/sample-tick paths as a drop-in superset.

Parameters:
NUM_CNT_BITS, 4, width of count_out, rollover_val, load_val
PRESCALE_BITS, 4, width of prescale_val and the internal prescaler counter

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  reset; asynchronous, active-low
clear  in  1  synchronous clear, highest priority
count_enable  in  1  advances the prescaler when high
load  in  1  synchronous parallel load
load_val  in  NUM_CNT_BITS  value loaded into count_out
dir  in  1  1 = count up, 0 = count down
mode  in  2  0 = WRAP, 1 = SATURATE, 2 = ONESHOT, 3 = reserved (treated as WRAP)
rollover_val  in  NUM_CNT_BITS  top of the count range
prescale_val  in  PRESCALE_BITS  tick every prescale_val+1 enabled cycles
count_out  out  NUM_CNT_BITS  current count
rollover_flag  out  1  high while count_out equals the terminal value
tc_pulse  out  1  one-cycle pulse on entry to the terminal value
done  out  1  ONESHOT has finished
busy  out  1  equals ~done

Behaviour:
- Reset (nRST low, asynchronous): count_out=0, rollover_flag=0, tc_pulse=0, prescaler=0, state=RUN, done=0, busy=1.
- Terminal value: rollover_val when dir=1; 1 when dir=0.
- Priority each cycle: clear > load > tick.
- Tick: count_enable=1 and prescaler==prescale_val. On a tick the prescaler goes to 0; otherwise it increments while enabled and holds when disabled. prescale_val=0 ticks on every enabled cycle.
- clear: count_out=0, prescaler=0, flags=0, state=RUN.
- load: count_out=load_val (not clamped), prescaler=0, state=RUN, tc_pulse=0, rollover_flag=(load_val==terminal).
- Up tick:
  - count_out < rollover_val: count+1.
  - count_out >= rollover_val: WRAP gives 1; SATURATE/ONESHOT hold.
- Down tick:
  - count_out==0 or count_out > rollover_val: next = rollover_val.
  - count_out==1: WRAP gives rollover_val; SATURATE/ONESHOT hold.
  - otherwise: count-1.
- rollover_val==0: ticks leave count_out at 0; rollover_flag=0 for dir=1.
- All outputs are registered; the new count is visible one cycle after the tick.
- rollover_flag(next) = (next_count==terminal) & (rollover_val!=0).
- tc_pulse(next) = 1 only when a tick moves count_out from a non-terminal value to the terminal value. A hold at terminal gives 0.
- FSM, 2 states:
  - RUN -> DONE: mode=ONESHOT and a tick produces terminal.
  - DONE: ticks are ignored, done=1, busy=0, count and rollover_flag hold.
  - DONE -> RUN: on clear or load only.
  - A mode change while in DONE does not leave DONE.
- Simultaneous clear+load: clear wins. load with a tick: load wins and the tick is dropped.
- dir or rollover_val changed mid-count: takes effect on the next tick using the rules above.
- Reset asserted mid-count aborts immediately. The first tick after release needs prescale_val+1 enabled cycles.

Decomposition:
- Package flex_counter_pkg:
  - mode_t enum {MODE_WRAP, MODE_SAT, MODE_ONESHOT}
  - state_t enum {RUN, DONE}
  - default width constants
- Sub-module flex_prescaler (CLK, nRST, clear_i = clear|load, en, prescale_val, tick). Its own counter is PRESCALE_BITS wide.
- Top holds the next-state count logic, the FSM and the output registers.

Test Plan:
- Up WRAP, rollover_val=5, prescale_val=0, enable held -> count_out 1,2,3,4,5,1,2; rollover_flag high only while count_out=5; one tc_pulse per wrap.
- prescale_val=2, up WRAP, rollover_val=3 -> count_out steps every 3 enabled cycles; deasserting enable for 4 cycles freezes both the count and the prescaler.
- ONESHOT up, rollover_val=4 -> stops at 4, done=1, busy=0; 10 further ticks leave count_out=4; load with load_val=2 -> count_out=2, done=0, counting resumes 3,4 and stops again.
- Down SATURATE, rollover_val=6, starting after clear -> 6,5,4,3,2,1,1,1; tc_pulse exactly once on 2->1; rollover_flag high from the first 1.
- clear and load together with load_val=7 -> count_out=0, rollover_flag=0. Then load with load_val=9 and rollover_val=5 up WRAP -> next tick gives 1.
- Assert nRST asynchronously mid-count (count_out=3, between clock edges) -> outputs go to 0 immediately. The first increment after release takes exactly prescale_val+1 enabled cycles.
